// File: rtl/ahb_mtx_in_stg_pkg.sv
// Shared definitions for the AHB matrix per-master input stage:
// transfer/response encodings and the held control-group payload.
package ahb_mtx_in_stg_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned CTRL_W = 18;

    // Address-phase control group captured alongside the address
    typedef struct packed {
        logic [1:0] trans;
        logic       write;
        logic [2:0] size;
        logic [2:0] burst;
        logic [3:0] prot;
        logic [3:0] master;
        logic       mastlock;
    } ahb_ctrl_t;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_HOLD = 1'b1
    } stg_state_e;

    // NONSEQ and SEQ are the only transfer types that request a slave
    function automatic logic is_req_trans(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_mtx_in_stg_if.sv
// Master-port AHB signal bundle seen by the input stage.
interface ahb_mtx_in_stg_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned USER_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              HSELS;
    logic [ADDR_W-1:0] HADDRS;
    logic [USER_W-1:0] HAUSERS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic [3:0]        HMASTERS;
    logic              HMASTLOCKS;
    logic              HREADYS;
    logic [DATA_W-1:0] HWDATAS;
    logic [USER_W-1:0] HWUSERS;
    logic              HREADYOUTS;
    logic              HRESPS;

    modport master (
        output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
               HPROTS, HMASTERS, HMASTLOCKS, HREADYS, HWDATAS, HWUSERS,
        input  HREADYOUTS, HRESPS
    );

    modport slave (
        input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS,
               HPROTS, HMASTERS, HMASTLOCKS, HREADYS, HWDATAS, HWUSERS,
        output HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/ahb_mtx_in_stg.sv
// Per-master input stage of the L1 AHB bus matrix: holds an accepted address
// phase until an output stage grants this port, stalling the master meanwhile.
module ahb_mtx_in_stg
    import ahb_mtx_in_stg_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned USER_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_mtx_in_stg_if.slave   ahb,
    output logic              sel_ip,
    output logic [ADDR_W-1:0] addr_ip,
    output logic [USER_W-1:0] auser_ip,
    output logic [1:0]        trans_ip,
    output logic              write_ip,
    output logic [2:0]        size_ip,
    output logic [2:0]        burst_ip,
    output logic [3:0]        prot_ip,
    output logic [3:0]        master_ip,
    output logic              mastlock_ip,
    output logic [DATA_W-1:0] wdata_ip,
    output logic [USER_W-1:0] wuser_ip,
    output logic              held_tran_ip,
    input  logic              active_ip,
    input  logic              readymux_ip,
    input  logic              readyout_ip,
    input  logic              resp_ip
);

    stg_state_e        state_q, state_d;
    logic              data_phase_q, data_phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [USER_W-1:0] auser_q, auser_d;
    ahb_ctrl_t         ctrl_q, ctrl_d;
    ahb_ctrl_t         ctrl_live;
    ahb_ctrl_t         ctrl_out;
    logic              pend_c;
    logic              accept_c;
    logic              issue_c;

    assign ctrl_live = '{
        trans:    ahb.HTRANSS,
        write:    ahb.HWRITES,
        size:     ahb.HSIZES,
        burst:    ahb.HBURSTS,
        prot:     ahb.HPROTS,
        master:   ahb.HMASTERS,
        mastlock: ahb.HMASTLOCKS
    };

    assign pend_c       = (state_q == ST_HOLD);
    assign accept_c     = ahb.HSELS & ahb.HREADYS & is_req_trans(ahb.HTRANSS);
    assign held_tran_ip = pend_c | accept_c;
    assign issue_c      = held_tran_ip & active_ip & readymux_ip;

    // State, data-phase flag and held address/control bank
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_PASS;
            data_phase_q <= 1'b0;
            addr_q       <= '0;
            auser_q      <= '0;
            ctrl_q       <= '0;
        end else begin
            state_q      <= state_d;
            data_phase_q <= data_phase_d;
            addr_q       <= addr_d;
            auser_q      <= auser_d;
            ctrl_q       <= ctrl_d;
        end
    end

    // Capture only from pass-through; a held transfer is never overwritten
    always_comb begin
        state_d      = state_q;
        data_phase_d = data_phase_q;
        addr_d       = addr_q;
        auser_d      = auser_q;
        ctrl_d       = ctrl_q;

        case (state_q)
            ST_PASS: begin
                if (accept_c && !issue_c) begin
                    state_d = ST_HOLD;
                    addr_d  = ahb.HADDRS;
                    auser_d = ahb.HAUSERS;
                    ctrl_d  = ctrl_live;
                end
            end
            ST_HOLD: begin
                if (issue_c) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase

        // The master's data phase is frozen while it is stalled by a hold
        if (!pend_c) begin
            if (issue_c) begin
                data_phase_d = 1'b1;
            end else if (data_phase_q && readyout_ip) begin
                data_phase_d = 1'b0;
            end
        end
    end

    always_comb begin
        sel_ip   = ahb.HSELS;
        addr_ip  = ahb.HADDRS;
        auser_ip = ahb.HAUSERS;
        ctrl_out = ctrl_live;
        if (pend_c) begin
            sel_ip   = 1'b1;
            addr_ip  = addr_q;
            auser_ip = auser_q;
            ctrl_out = ctrl_q;
        end
    end

    assign trans_ip    = ctrl_out.trans;
    assign write_ip    = ctrl_out.write;
    assign size_ip     = ctrl_out.size;
    assign burst_ip    = ctrl_out.burst;
    assign prot_ip     = ctrl_out.prot;
    assign master_ip   = ctrl_out.master;
    assign mastlock_ip = ctrl_out.mastlock;

    // Write data is steered by the output stage's own data-phase port
    assign wdata_ip = ahb.HWDATAS;
    assign wuser_ip = ahb.HWUSERS;

    assign ahb.HREADYOUTS = pend_c ? 1'b0 : (data_phase_q ? readyout_ip : 1'b1);
    assign ahb.HRESPS     = (data_phase_q && !pend_c) ? resp_ip : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Bench for ahb_mtx_in_stg: directed scenarios plus random traffic, with a
// transaction-level reference model and an issue-order scoreboard.
module tb_ahb_mtx_in_stg;
    import ahb_mtx_in_stg_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned USER_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] auser;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        mastlock;
    } txn_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_mtx_in_stg_if #(.ADDR_W(ADDR_W), .USER_W(USER_W), .DATA_W(DATA_W)) bus ();
    assign bus.HREADYS = bus.HREADYOUTS;

    logic              sel_ip, write_ip, mastlock_ip, held_tran_ip;
    logic [ADDR_W-1:0] addr_ip;
    logic [USER_W-1:0] auser_ip, wuser_ip;
    logic [1:0]        trans_ip;
    logic [2:0]        size_ip, burst_ip;
    logic [3:0]        prot_ip, master_ip;
    logic [DATA_W-1:0] wdata_ip;
    logic              active_ip, readymux_ip, readyout_ip, resp_ip;

    ahb_mtx_in_stg #(.ADDR_W(ADDR_W), .USER_W(USER_W), .DATA_W(DATA_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus),
        .sel_ip(sel_ip), .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip),
        .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
        .master_ip(master_ip), .mastlock_ip(mastlock_ip), .wdata_ip(wdata_ip),
        .wuser_ip(wuser_ip), .held_tran_ip(held_tran_ip), .active_ip(active_ip),
        .readymux_ip(readymux_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip)
    );

    int   n_chk   = 0;
    int   n_fail  = 0;
    int   n_issue = 0;
    bit   rnd_slave = 1'b0;
    txn_t exp_q[$];     // transfers the master has issued, in order
    txn_t m_hold[$];    // model: transfer parked in the stage (0 or 1 entries)
    bit   m_dp = 1'b0;  // model: master has a data phase in flight

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                input logic write, input logic [2:0] burst);
        txn_t t;
        t.sel = sel; t.addr = addr; t.auser = $urandom; t.trans = trans; t.write = write;
        t.size = 3'($urandom_range(0, 2)); t.burst = burst; t.prot = 4'($urandom);
        t.master = 4'($urandom); t.mastlock = 1'($urandom);
        return t;
    endfunction

    task automatic put_bus(input txn_t t);
        bus.HSELS = t.sel; bus.HADDRS = t.addr; bus.HAUSERS = t.auser; bus.HTRANSS = t.trans;
        bus.HWRITES = t.write; bus.HSIZES = t.size; bus.HBURSTS = t.burst; bus.HPROTS = t.prot;
        bus.HMASTERS = t.master; bus.HMASTLOCKS = t.mastlock;
        bus.HWDATAS = $urandom; bus.HWUSERS = $urandom;
    endtask

    // Master driver: present an address phase and wait until the master sees HREADY
    task automatic drive(input txn_t t, input int act);
        @(posedge HCLK); #1;
        put_bus(t);
        if (act >= 0) active_ip = act[0];
        if (t.sel && t.trans[1]) exp_q.push_back(t);
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (bus.HREADYOUTS === 1'b1) return;
        end
        n_chk++; n_fail++;
        $display("FAIL drive_timeout: HREADYOUTS stuck, addr %0h", t.addr);
    endtask

    task automatic idle(input int n);
        txn_t t;
        t = '0;
        @(posedge HCLK); #1;
        put_bus(t);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic set_slave(input bit act, input bit mux, input bit rdy, input bit rsp);
        active_ip = act; readymux_ip = mux; readyout_ip = rdy; resp_ip = rsp;
    endtask

    initial begin : slave_rand
        forever begin
            @(posedge HCLK); #1;
            if (rnd_slave) begin
                active_ip   = ($urandom_range(0, 2) != 0);
                readymux_ip = ($urandom_range(0, 3) != 0);
                readyout_ip = ($urandom_range(0, 2) != 0);
                resp_ip     = ($urandom_range(0, 4) == 0);
            end
        end
    end

    // Monitor: predict outputs from the model and score every issued transfer
    initial begin : monitor
        txn_t live, dut_out, e_out, t;
        bit   pend, e_hro, e_resp, acc, e_held, issue;
        forever begin
            @(negedge HCLK);
            if (HRESETn !== 1'b1) begin
                m_hold.delete();
                m_dp = 1'b0;
                continue;
            end
            live = '{sel: bus.HSELS, addr: bus.HADDRS, auser: bus.HAUSERS, trans: bus.HTRANSS,
                     write: bus.HWRITES, size: bus.HSIZES, burst: bus.HBURSTS, prot: bus.HPROTS,
                     master: bus.HMASTERS, mastlock: bus.HMASTLOCKS};
            dut_out = '{sel: sel_ip, addr: addr_ip, auser: auser_ip, trans: trans_ip,
                        write: write_ip, size: size_ip, burst: burst_ip, prot: prot_ip,
                        master: master_ip, mastlock: mastlock_ip};
            pend   = (m_hold.size() != 0);
            e_hro  = pend ? 1'b0 : (m_dp ? readyout_ip : 1'b1);
            e_resp = (m_dp && !pend) ? resp_ip : 1'b0;
            acc    = bus.HSELS & e_hro & bus.HTRANSS[1];
            e_held = pend | acc;
            issue  = e_held & active_ip & readymux_ip;
            e_out  = live;
            if (pend) begin
                e_out = m_hold[0];
                e_out.sel = 1'b1;
            end
            check("hreadyouts", 128'(bus.HREADYOUTS), 128'(e_hro));
            check("hresps", 128'(bus.HRESPS), 128'(e_resp));
            check("held_tran", 128'(held_tran_ip), 128'(e_held));
            check("addr_ctrl", 128'(dut_out), 128'(e_out));
            check("wdata_pass", 128'({wuser_ip, wdata_ip}), 128'({bus.HWUSERS, bus.HWDATAS}));
            if (held_tran_ip && active_ip && readymux_ip) begin
                n_issue++;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL issue_order: unexpected issue addr %0h", addr_ip);
                end else begin
                    t = exp_q.pop_front();
                    check("issue_txn", 128'(dut_out), 128'(t));
                end
            end
            if (!pend && acc && !issue) m_hold.push_back(live);
            else if (pend && issue) m_hold.delete();
            if (!pend) begin
                if (issue) m_dp = 1'b1;
                else if (m_dp && readyout_ip) m_dp = 1'b0;
            end
        end
    end

    initial begin : stim
        txn_t t;
        int   base;
        HRESETn = 1'b0;
        t = '0;
        put_bus(t);
        set_slave(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check("rst_hreadyouts", 128'(bus.HREADYOUTS), 128'(1));
        check("rst_hresps", 128'(bus.HRESPS), 128'(0));
        check("rst_held_tran", 128'(held_tran_ip), 128'(0));
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Same-cycle pass-through write
        set_slave(1'b1, 1'b1, 1'b1, 1'b0);
        base = n_issue;
        drive(mk(1'b1, HTRANS_NONSEQ, 32'h2000_0010, 1'b1, 3'b000), 1);
        check("pt_issue_now", 128'(n_issue - base), 128'(1));
        check("pt_addr", 128'(addr_ip), 128'(32'h2000_0010));
        @(posedge HCLK); #1 readyout_ip = 1'b0;
        bus.HTRANSS = HTRANS_IDLE; bus.HSELS = 1'b0;
        @(negedge HCLK);
        check("pt_dp_wait", 128'(bus.HREADYOUTS), 128'(0));
        @(posedge HCLK); #1 readyout_ip = 1'b1;
        @(negedge HCLK);
        check("pt_dp_done", 128'(bus.HREADYOUTS), 128'(1));
        idle(2);

        // Held read: no grant for three cycles while the master moves on
        set_slave(1'b0, 1'b1, 1'b1, 1'b0);
        drive(mk(1'b1, HTRANS_NONSEQ, 32'h4000_0000, 1'b0, 3'b000), 0);
        fork
            drive(mk(1'b1, HTRANS_NONSEQ, 32'h4000_0100, 1'b1, 3'b000), -1);
            begin
                @(negedge HCLK);
                check("hold_stall", 128'(bus.HREADYOUTS), 128'(0));
                check("hold_addr", 128'(addr_ip), 128'(32'h4000_0000));
                repeat (2) @(posedge HCLK);
                #1 active_ip = 1'b1;
            end
        join
        idle(3);

        // INCR4 burst with a grant gap on the third beat
        base = n_issue;
        for (int b = 0; b < 4; b++)
            drive(mk(1'b1, (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h3000_0000 + 32'(4 * b),
                     1'b1, 3'b011), (b == 2) ? 0 : 1);
        idle(3);
        check("incr4_issues", 128'(n_issue - base), 128'(4));

        // Two-cycle ERROR response
        set_slave(1'b1, 1'b1, 1'b1, 1'b0);
        drive(mk(1'b1, HTRANS_NONSEQ, 32'h5000_0000, 1'b1, 3'b000), 1);
        @(posedge HCLK); #1;
        bus.HTRANSS = HTRANS_IDLE; bus.HSELS = 1'b0;
        readyout_ip = 1'b0; resp_ip = 1'b1;
        @(negedge HCLK);
        check("err1_resp", 128'(bus.HRESPS), 128'(1));
        check("err1_ready", 128'(bus.HREADYOUTS), 128'(0));
        @(posedge HCLK); #1 readyout_ip = 1'b1;
        @(negedge HCLK);
        check("err2_resp", 128'(bus.HRESPS), 128'(1));
        check("err2_ready", 128'(bus.HREADYOUTS), 128'(1));
        @(posedge HCLK); #1 resp_ip = 1'b0;
        @(negedge HCLK);
        check("err_dp_clear", 128'(bus.HRESPS), 128'(0));

        // Reset while a transfer is held
        set_slave(1'b0, 1'b1, 1'b1, 1'b0);
        drive(mk(1'b1, HTRANS_NONSEQ, 32'h6000_0000, 1'b0, 3'b000), 0);
        @(posedge HCLK); #1;
        t = '0;
        put_bus(t);
        check("pre_rst_hold", 128'(held_tran_ip), 128'(1));
        #2 HRESETn = 1'b0;
        #1;
        check("midrst_ready", 128'(bus.HREADYOUTS), 128'(1));
        check("midrst_held", 128'(held_tran_ip), 128'(0));
        exp_q.delete();
        @(posedge HCLK); #1 HRESETn = 1'b1;
        idle(2);

        // IDLE and BUSY with select: no request, no capture
        set_slave(1'b0, 1'b1, 1'b1, 1'b0);
        drive(mk(1'b1, HTRANS_IDLE, 32'h7000_0000, 1'b0, 3'b000), -1);
        check("idle_no_req", 128'(held_tran_ip), 128'(0));
        drive(mk(1'b1, HTRANS_BUSY, 32'h7000_0004, 1'b0, 3'b001), -1);
        check("busy_no_req", 128'(held_tran_ip), 128'(0));
        check("busy_pass", 128'(trans_ip), 128'(HTRANS_BUSY));
        @(negedge HCLK);
        check("busy_ready", 128'(bus.HREADYOUTS), 128'(1));

        // Random traffic against random output-stage behaviour
        rnd_slave = 1'b1;
        for (int i = 0; i < 400; i++) begin
            t = mk(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 3'($urandom));
            drive(t, -1);
        end
        rnd_slave = 1'b0;
        @(posedge HCLK); #1 set_slave(1'b1, 1'b1, 1'b1, 1'b0);
        idle(6);
        check("drain_queue", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
